wrd_frame_pack: RTL

//   Upstream neighbour of the word-recognition top. Serial MFCC coefficients

---
 rtl/wrd_frame_pack_if.sv | 24 ++
 rtl/wrd_frame_pack.sv | 74 +++++++
 2 files changed

// File: rtl/wrd_frame_pack_if.sv
// rtl/wrd_frame_pack_if.sv - coefficient input and packed-vector output streams of wrd_frame_pack
interface wrd_frame_pack_if #(
   parameter int BW         = 8,
   parameter int VECTOR_LEN = 13
);
   logic [BW-1:0]            data_i;
   logic                     valid_i;
   logic                     first_i;
   logic                     ready_o;
   logic [BW*VECTOR_LEN-1:0] data_o;
   logic                     valid_o;
   logic                     last_o;
   logic                     ready_i;

   modport slave (
      input  data_i, valid_i, first_i, ready_i,
      output ready_o, data_o, valid_o, last_o
   );

   modport master (
      output data_i, valid_i, first_i, ready_i,
      input  ready_o, data_o, valid_o, last_o
   );
endinterface

// File: rtl/wrd_frame_pack.sv
// rtl/wrd_frame_pack.sv - packs serial MFCC bytes into 13-lane vectors, framed in groups of 50
module wrd_frame_pack #(
   parameter int BW         = 8,
   parameter int VECTOR_LEN = 13,
   parameter int FRAME_LEN  = 50
) (
   input  logic            clk_i,
   input  logic            rst_i,
   wrd_frame_pack_if.slave s,
   output logic            err_o,
   input  logic            clr_err_i
);
   localparam int CW = $clog2(VECTOR_LEN);
   localparam int VW = $clog2(FRAME_LEN);
   localparam logic [CW-1:0] COEF_LAST = CW'(VECTOR_LEN - 1);
   localparam logic [VW-1:0] VEC_LAST  = VW'(FRAME_LEN - 1);

   logic [CW-1:0]                coef_cnt;
   logic [VW-1:0]                vec_cnt;
   logic [(VECTOR_LEN-1)*BW-1:0] asm_q;
   logic                         accept;
   logic                         misaligned;

   // Only the final lane can stall: it needs the output register free.
   assign s.ready_o  = !rst_i && (coef_cnt != COEF_LAST || !s.valid_o || s.ready_i);
   assign accept     = s.valid_i && s.ready_o;
   assign misaligned = (coef_cnt != '0) || (vec_cnt != '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         coef_cnt  <= '0;
         vec_cnt   <= '0;
         asm_q     <= '0;
         s.data_o  <= '0;
         s.valid_o <= 1'b0;
         s.last_o  <= 1'b0;
      end else begin
         if (s.valid_o && s.ready_i) begin
            s.valid_o <= 1'b0;
            s.last_o  <= 1'b0;
         end
         if (accept) begin
            if (s.first_i) begin
               asm_q         <= '0;
               asm_q[BW-1:0] <= s.data_i;
               coef_cnt      <= CW'(1);
               vec_cnt       <= '0;
            end else if (coef_cnt == COEF_LAST) begin
               // Load overrides the drain clear above.
               s.data_o  <= {s.data_i, asm_q};
               s.valid_o <= 1'b1;
               s.last_o  <= (vec_cnt == VEC_LAST);
               coef_cnt  <= '0;
               vec_cnt   <= (vec_cnt == VEC_LAST) ? '0 : vec_cnt + 1'b1;
            end else begin
               for (int k = 0; k < VECTOR_LEN - 1; k++) begin
                  if (coef_cnt == CW'(k)) asm_q[k*BW +: BW] <= s.data_i;
               end
               coef_cnt <= coef_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_o <= 1'b0;
      end else if (accept && s.first_i && misaligned) begin
         err_o <= 1'b1;
      end else if (clr_err_i) begin
         err_o <= 1'b0;
      end
   end
endmodule
